// File: rtl/cpu_pkg.sv
// Shared definitions for the boot loader: header byte, instruction width,
// and the state encodings of the framing FSM and the UART receiver.
package cpu_pkg;

    localparam logic [7:0] LOADER_HDR = 8'hA5;
    localparam int         INS_W      = 32;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_CNT_HI,
        LD_CNT_LO,
        LD_DATA,
        LD_WRITE,
        LD_FINISH,
        LD_ERR
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, glitch rejection on
// the start bit, and a one-cycle byte_valid or frame_err per received frame.
module uart_rx
    import cpu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       sync_reg;
    logic             rx_s;
    rx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             byte_valid_reg, byte_valid_next;
    logic             frame_err_reg, frame_err_next;

    // Synchronizer stages reset to the idle (high) line level.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) sync_reg[gi] <= 1'b1;
                    else        sync_reg[gi] <= rx;
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) sync_reg[gi] <= 1'b1;
                    else        sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rx_s = sync_reg[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= RX_IDLE;
            cnt_reg        <= '0;
            bit_reg        <= '0;
            shift_reg      <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_reg        <= bit_next;
            shift_reg      <= shift_next;
            byte_valid_reg <= byte_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        bit_next        = bit_reg;
        shift_next      = shift_reg;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_next = RX_START;
                    cnt_next   = '0;
                end
            end
            RX_START: begin
                // A start bit that is gone by mid-bit was noise, not a frame.
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_reg == FULL_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift_reg[7:1]};
                    if (bit_reg == 3'd7) state_next = RX_STOP;
                    else                 bit_next   = bit_reg + 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_reg == FULL_LAST) begin
                    state_next      = RX_IDLE;
                    byte_valid_next = rx_s;
                    frame_err_next  = !rx_s;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign byte_valid = byte_valid_reg;
    assign byte_data  = shift_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed program image over UART and writes it
// into instruction memory, holding the CPU in reset for the duration of the load.
module prog_loader
    import cpu_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 115_200,
    parameter int ADDR_W       = 10,
    parameter int TIMEOUT_CLKS = CLK_HZ / 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [INS_W-1:0]  im_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int              CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int              MAX_WORDS    = 2 ** ADDR_W;
    localparam int              TMO_W        = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CLKS - 1);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    ld_state_t         state_reg, state_next;
    logic [15:0]       n_reg, n_next;
    logic [23:0]       shift_reg, shift_next;
    logic [1:0]        bcnt_reg, bcnt_next;
    logic [ADDR_W:0]   wl_reg, wl_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [INS_W-1:0]  wdata_reg, wdata_next;
    logic              cpu_reset_reg, cpu_reset_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;
    logic              tmo_active, abort;
    logic [15:0]       n_full;
    logic [ADDR_W:0]   wl_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= LD_IDLE;
            n_reg         <= '0;
            shift_reg     <= '0;
            bcnt_reg      <= '0;
            wl_reg        <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            cpu_reset_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            tmo_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            n_reg         <= n_next;
            shift_reg     <= shift_next;
            bcnt_reg      <= bcnt_next;
            wl_reg        <= wl_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            cpu_reset_reg <= cpu_reset_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            tmo_reg       <= tmo_next;
        end
    end

    assign tmo_active = (state_reg == LD_CNT_HI) || (state_reg == LD_CNT_LO) ||
                        (state_reg == LD_DATA)   || (state_reg == LD_WRITE);
    assign abort      = ((state_reg == LD_CNT_HI) || (state_reg == LD_CNT_LO) ||
                         (state_reg == LD_DATA)) && (frame_err || (tmo_reg == TMO_LAST));
    assign n_full     = {n_reg[15:8], byte_data};
    assign wl_inc     = wl_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        n_next         = n_reg;
        shift_next     = shift_reg;
        bcnt_next      = bcnt_reg;
        wl_next        = wl_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        cpu_reset_next = cpu_reset_reg;
        busy_next      = busy_reg;
        done_next      = done_reg;
        err_next       = err_reg;

        // The timeout restarts on every byte and saturates so it cannot wrap.
        if (byte_valid || !tmo_active) tmo_next = '0;
        else if (tmo_reg != TMO_LAST)  tmo_next = tmo_reg + 1'b1;
        else                           tmo_next = tmo_reg;

        if (abort) begin
            state_next = LD_ERR;
            err_next   = 1'b1;
            busy_next  = 1'b0;
        end else begin
            case (state_reg)
                LD_IDLE, LD_ERR: begin
                    if (byte_valid && byte_data == LOADER_HDR) begin
                        state_next     = LD_CNT_HI;
                        cpu_reset_next = 1'b1;
                        busy_next      = 1'b1;
                        done_next      = 1'b0;
                        err_next       = 1'b0;
                        wl_next        = '0;
                    end
                end
                LD_CNT_HI: begin
                    if (byte_valid) begin
                        n_next[15:8] = byte_data;
                        state_next   = LD_CNT_LO;
                    end
                end
                LD_CNT_LO: begin
                    if (byte_valid) begin
                        n_next    = n_full;
                        bcnt_next = '0;
                        if (n_full == 16'd0) begin
                            state_next = LD_FINISH;
                        end else if (32'(n_full) > MAX_WORDS) begin
                            state_next = LD_ERR;
                            err_next   = 1'b1;
                            busy_next  = 1'b0;
                        end else begin
                            state_next = LD_DATA;
                        end
                    end
                end
                LD_DATA: begin
                    if (byte_valid) begin
                        bcnt_next = bcnt_reg + 1'b1;
                        if (bcnt_reg == 2'd3) begin
                            wdata_next = {shift_reg, byte_data};
                            addr_next  = wl_reg[ADDR_W-1:0];
                            state_next = LD_WRITE;
                        end else begin
                            shift_next = {shift_reg[15:0], byte_data};
                        end
                    end
                end
                LD_WRITE: begin
                    wl_next    = wl_inc;
                    state_next = (32'(wl_inc) == 32'(n_reg)) ? LD_FINISH : LD_DATA;
                end
                LD_FINISH: begin
                    cpu_reset_next = 1'b0;
                    busy_next      = 1'b0;
                    done_next      = 1'b1;
                    state_next     = LD_IDLE;
                end
                default: state_next = LD_IDLE;
            endcase
        end
    end

    assign im_we        = (state_reg == LD_WRITE);
    assign im_addr      = addr_reg;
    assign im_wdata     = wdata_reg;
    assign cpu_reset    = cpu_reset_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign err          = err_reg;
    assign words_loaded = wl_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized and directed bench for prog_loader against a frame-level model.
`timescale 1ns/1ps
module tb_prog_loader;

    localparam int CPB    = 10;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rx = 1'b1;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_reset, busy, done, err;
    logic [ADDR_W:0]   words_loaded;

    always #5 clk = ~clk;

    prog_loader #(
        .CLK_HZ      (1_000_000),
        .BAUD        (100_000),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CLKS(500)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .im_we       (im_we),
        .im_addr     (im_addr),
        .im_wdata    (im_wdata),
        .cpu_reset   (cpu_reset),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .words_loaded(words_loaded)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write monitor, sampled on the falling edge
    int          cyc = 0;
    int          last_we_cyc = 0;
    int          fall_cyc = -100;
    int          cr_hi_cnt = 0;
    logic        prev_cr = 1'b0;
    logic [41:0] wr_q[$];
    logic [41:0] exp_q[$];
    logic [31:0] tb_mem[1024];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (im_we) begin
            wr_q.push_back({im_addr, im_wdata});
            tb_mem[im_addr] = im_wdata;
            last_we_cyc = cyc;
        end
        if (prev_cr && !cpu_reset) fall_cyc = cyc;
        if (cpu_reset) cr_hi_cnt++;
        prev_cr = cpu_reset;
    end

    task automatic clear_obs();
        wr_q.delete();
        exp_q.delete();
        fall_cyc = -100;
        last_we_cyc = 0;
        cr_hi_cnt = 0;
    endtask

    // nbits < 10 sends only the leading bits of the frame (start + data).
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            if (i == 0)      rx = 1'b0;
            else if (i < 9)  rx = b[i-1];
            else             rx = stop_ok;
            repeat (CPB - 1) @(negedge clk);
        end
        if (nbits == 10) begin
            @(negedge clk);
            rx = 1'b1;
            repeat (CPB - 1) @(negedge clk);
        end
    endtask

    task automatic send_seq(input logic [7:0] q[$], input int from);
        for (int i = from; i < q.size(); i++) send_byte(q[i], 1'b1, 10);
    endtask

    // Frame-level reference: skip to the header, read N, slice 4N bytes into words.
    task automatic model(input logic [7:0] q[$], output bit ed, output bit ee, output int ewl);
        int i = 0;
        int n;
        while (i < q.size() && q[i] != 8'hA5) i++;
        n = int'({q[i+1], q[i+2]});
        i += 3;
        if (n > 1024) begin
            ed = 0; ee = 1; ewl = 0;
        end else begin
            ed = 1; ee = 0; ewl = n;
            for (int k = 0; k < n; k++)
                exp_q.push_back({10'(k), q[i+4*k], q[i+4*k+1], q[i+4*k+2], q[i+4*k+3]});
        end
    endtask

    task automatic check_load(input string tag, input bit ed, input bit ee, input int ewl);
        check_val({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            if (k < wr_q.size()) check_val({tag, "_wr"}, 64'(wr_q[k]), 64'(exp_q[k]));
        check_val({tag, "_done"}, 64'(done), 64'(ed));
        check_val({tag, "_err"}, 64'(err), 64'(ee));
        check_val({tag, "_busy"}, 64'(busy), 64'(0));
        check_val({tag, "_cpurst"}, 64'(cpu_reset), 64'(ee));
        check_val({tag, "_wl"}, 64'(words_loaded), 64'(ewl));
        if (exp_q.size() > 0)
            check_val({tag, "_rstdly"}, 64'(fall_cyc - last_we_cyc), 64'(2));
        $display("load %s words=%0d writes=%0d done=%0b err=%0b", tag, ewl, wr_q.size(), done, err);
    endtask

    task automatic rand_frame(output logic [7:0] q[$], input int n);
        int junk = $urandom_range(0, 2);
        logic [7:0] v;
        q.delete();
        for (int j = 0; j < junk; j++) begin
            v = 8'($urandom);
            if (v == 8'hA5) v = 8'h5A;
            q.push_back(v);
        end
        q.push_back(8'hA5);
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        for (int j = 0; j < 4 * n; j++) q.push_back(8'($urandom));
    endtask

    initial begin
        logic [7:0] q[$];
        bit ed, ee;
        int ewl;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("reset_outs", 64'({im_we, im_addr, im_wdata, cpu_reset, busy, done, err, words_loaded}), 64'(0));
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // 1: two-word load
        clear_obs();
        q = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        model(q, ed, ee, ewl);
        send_byte(q[0], 1'b1, 10);
        check_val("t1_hold_cpurst", 64'(cpu_reset), 64'(1));
        check_val("t1_hold_busy", 64'(busy), 64'(1));
        send_seq(q, 1);
        repeat (10) @(negedge clk);
        check_load("t1", ed, ee, ewl);

        // 2: leading junk then empty image
        clear_obs();
        q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
        model(q, ed, ee, ewl);
        send_seq(q, 0);
        repeat (10) @(negedge clk);
        check_load("t2", ed, ee, ewl);
        check_val("t2_pulse", 64'(cr_hi_cnt > 0), 64'(1));

        // 3: oversize count, then recovery load
        clear_obs();
        q = '{8'hA5, 8'h04, 8'h01};
        model(q, ed, ee, ewl);
        send_seq(q, 0);
        repeat (10) @(negedge clk);
        check_load("t3a", ed, ee, ewl);
        clear_obs();
        q = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        model(q, ed, ee, ewl);
        send_byte(q[0], 1'b1, 10);
        check_val("t3_err_clr", 64'(err), 64'(0));
        send_seq(q, 1);
        repeat (10) @(negedge clk);
        check_load("t3b", ed, ee, ewl);
        check_val("t3_mem0", 64'(tb_mem[0]), 64'(32'h11223344));

        // 4: inter-byte timeout
        clear_obs();
        q = '{8'hA5, 8'h00, 8'h01, 8'hAA, 8'hBB};
        send_seq(q, 0);
        repeat (400) @(negedge clk);
        check_val("t4_err_early", 64'(err), 64'(0));
        repeat (200) @(negedge clk);
        check_val("t4_err", 64'(err), 64'(1));
        check_val("t4_busy", 64'(busy), 64'(0));
        check_val("t4_cpurst", 64'(cpu_reset), 64'(1));
        check_val("t4_nwr", 64'(wr_q.size()), 64'(0));
        $display("load t4 timeout err=%0b", err);

        // 5: bad stop bit, then start-bit glitch in IDLE
        clear_obs();
        q = '{8'hA5, 8'h00, 8'h01};
        send_seq(q, 0);
        send_byte(8'hAA, 1'b0, 10);
        repeat (200) @(negedge clk);
        check_val("t5_err", 64'(err), 64'(1));
        check_val("t5_nwr", 64'(wr_q.size()), 64'(0));
        $display("load t5 frame_err err=%0b", err);
        q = '{8'hA5, 8'h00, 8'h00};
        send_seq(q, 0);
        repeat (10) @(negedge clk);
        clear_obs();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (15) @(negedge clk);
        check_val("t5_glitch_busy", 64'(busy), 64'(0));
        check_val("t5_glitch_done", 64'(done), 64'(1));
        rand_frame(q, 1);
        model(q, ed, ee, ewl);
        send_seq(q, 0);
        repeat (10) @(negedge clk);
        check_load("t5_after_glitch", ed, ee, ewl);

        // 6: asynchronous reset mid-byte
        clear_obs();
        send_byte(8'hA5, 1'b1, 10);
        send_byte(8'h00, 1'b1, 10);
        send_byte(8'h02, 1'b1, 5);
        check_val("t6_pre_cpurst", 64'(cpu_reset), 64'(1));
        check_val("t6_pre_busy", 64'(busy), 64'(1));
        #2 reset = 1'b0;
        #1 check_val("t6_async_outs", 64'({im_we, im_addr, im_wdata, cpu_reset, busy, done, err, words_loaded}), 64'(0));
        rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        clear_obs();
        rand_frame(q, 2);
        model(q, ed, ee, ewl);
        send_seq(q, 0);
        repeat (10) @(negedge clk);
        check_load("t6_reload", ed, ee, ewl);

        // Randomized loads
        for (int it = 0; it < 4; it++) begin
            clear_obs();
            rand_frame(q, $urandom_range(1, 6));
            model(q, ed, ee, ewl);
            send_seq(q, 0);
            repeat (10) @(negedge clk);
            check_load($sformatf("rnd%0d", it), ed, ee, ewl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
